// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler: time-multiplexed 6-input truth-table evaluation of one quantised LogicNets layer
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   cfg_we_i     configuration write strobe (honoured in IDLE only)
//   cfg_addr_i   neuron number being configured (>= NUM_NEURONS ignored)
//   cfg_tt_i     truth table, bit a is the output for lookup address a
//   cfg_idx_i    fan-in indices, field j at [j*IDX_W +: IDX_W]
//   cfg_ready_o  configuration write would be accepted
//   in_valid_i   input activation vector valid
//   in_ready_o   input vector can be accepted
//   in_data_i    input activation vector
//   out_valid_o  packed result valid
//   out_ready_i  downstream accepts the result
//   out_data_o   packed neuron outputs, bit n is neuron n
//   busy_o       any state other than IDLE
module lut_layer_scheduler #(
    parameter int IN_WIDTH    = 64,
    parameter int NUM_NEURONS = 32,
    parameter int FANIN       = 6,
    parameter int IDX_W       = 6,
    parameter int NADDR_W     = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_we_i,
    input  logic [NADDR_W-1:0]       cfg_addr_i,
    input  logic [2**FANIN-1:0]      cfg_tt_i,
    input  logic [FANIN*IDX_W-1:0]   cfg_idx_i,
    output logic                     cfg_ready_o,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [IN_WIDTH-1:0]      in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_NEURONS-1:0]   out_data_o,
    output logic                     busy_o
);
    localparam int TT_W = 2**FANIN;
    localparam int IX_W = FANIN*IDX_W;
    localparam int XP_W = 2**IDX_W;
    localparam logic [NADDR_W-1:0] LAST = NADDR_W'(NUM_NEURONS-1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

    state_e                  state_q, state_d;
    logic [NADDR_W-1:0]      cnt_q, cnt_d, tag_q, tag_d;
    logic                    sv_q, sv_d;
    logic [NUM_NEURONS-1:0]  acc_q, acc_d;
    logic [IN_WIDTH-1:0]     x_q, x_d;
    logic [TT_W-1:0]         tt_q, tt_d;
    logic [IX_W-1:0]         idx_q, idx_d;

    logic [TT_W-1:0]         tt_mem  [NUM_NEURONS];
    logic [IX_W-1:0]         idx_mem [NUM_NEURONS];

    logic                    addr_ok;
    logic [XP_W-1:0]         x_pad;
    logic [FANIN-1:0]        lut_addr;
    logic                    lut_bit;

    assign addr_ok     = {1'b0, cfg_addr_i} < (NADDR_W+1)'(NUM_NEURONS);
    assign cfg_ready_o = state_q == IDLE;
    assign in_ready_o  = state_q == IDLE && !cfg_we_i;
    assign out_valid_o = state_q == OUT;
    assign out_data_o  = state_q == OUT ? acc_q : '0;
    assign busy_o      = state_q != IDLE;

    // Configuration only lands in IDLE so a running transaction sees a frozen table.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && state_q == IDLE && addr_ok) begin
            tt_mem[cfg_addr_i]  <= cfg_tt_i;
            idx_mem[cfg_addr_i] <= cfg_idx_i;
        end
    end

    // Zero-extended activations make out-of-range indices read as 0.
    always_comb begin
        x_pad = '0;
        x_pad[IN_WIDTH-1:0] = x_q;
    end

    always_comb begin
        lut_addr = '0;
        for (int j = 0; j < FANIN; j++)
            lut_addr[j] = x_pad[idx_q[j*IDX_W +: IDX_W]];
    end

    assign lut_bit = tt_q[lut_addr];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        sv_d    = 1'b0;
        acc_d   = acc_q;
        x_d     = x_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        if (sv_q)
            acc_d[tag_q] = lut_bit;
        case (state_q)
            IDLE: begin
                if (!cfg_we_i && in_valid_i) begin
                    x_d     = in_data_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                tt_d    = tt_mem[cnt_q];
                idx_d   = idx_mem[cnt_q];
                tag_d   = cnt_q;
                sv_d    = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == LAST ? DRAIN : RUN;
            end
            DRAIN: state_d = OUT;
            OUT:   state_d = out_ready_i ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sv_q    <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sv_q    <= sv_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        x_q   <= x_d;
        tt_q  <= tt_d;
        idx_q <= idx_d;
        tag_q <= tag_d;
    end
endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb_lut_layer_scheduler: randomized and directed checks of lut_layer_scheduler against a behavioural layer model
module tb_lut_layer_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [63:0] cfg_tt = '0;
    logic [35:0] cfg_idx = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        cfg_ready_a, in_ready_a, out_valid_a, busy_a;
    logic [31:0] out_data_a;
    logic        cfg_ready_b, in_ready_b, out_valid_b, busy_b;
    logic [31:0] out_data_b;
    logic        cfg_we_a;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m_tt  [32];
    logic [35:0] m_idx [32];
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    // Instance A has the default 5-bit neuron address, so writes beyond 31 are kept off its bus.
    assign cfg_we_a = cfg_we & ~cfg_addr[5];

    lut_layer_scheduler dut_a (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we_a), .cfg_addr_i(cfg_addr[4:0]),
        .cfg_tt_i(cfg_tt), .cfg_idx_i(cfg_idx), .cfg_ready_o(cfg_ready_a),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a), .busy_o(busy_a)
    );

    lut_layer_scheduler #(.IN_WIDTH(40), .NADDR_W(6)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_tt_i(cfg_tt), .cfg_idx_i(cfg_idx), .cfg_ready_o(cfg_ready_b),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data[39:0]),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each neuron: gather its FANIN addressed activations (fan-in 0 as LSB), look the result up in its table.
    function automatic logic [31:0] model(input logic [63:0] x, input int w);
        logic [31:0] r = '0;
        for (int n = 0; n < 32; n++) begin
            int a = 0;
            for (int j = 0; j < 6; j++) begin
                int id = int'(m_idx[n][j*6 +: 6]);
                if (id < w && x[id]) a += (1 << j);
            end
            r[n] = m_tt[n][a];
        end
        return r;
    endfunction

    task automatic cfg_write(input int addr, input logic [63:0] tt, input logic [35:0] idx);
        cfg_we = 1'b1;
        cfg_addr = addr[5:0];
        cfg_tt = tt;
        cfg_idx = idx;
        step();
        cfg_we = 1'b0;
        if (addr < 32) begin
            m_tt[addr] = tt;
            m_idx[addr] = idx;
        end
    endtask

    function automatic logic [35:0] idx6(input int i5, i4, i3, i2, i1, i0);
        return {i5[5:0], i4[5:0], i3[5:0], i2[5:0], i1[5:0], i0[5:0]};
    endfunction

    function automatic logic [35:0] rand_idx();
        logic [35:0] r;
        for (int j = 0; j < 6; j++) r[j*6 +: 6] = 6'($urandom_range(0, 63));
        return r;
    endfunction

    task automatic send(input logic [63:0] x);
        int k = 0;
        while (!(in_ready_a && in_ready_b) && k < 200) begin
            step();
            k++;
        end
        if (k == 200) chk("in_ready_timeout", 64'(in_ready_a), 64'd1);
        in_valid = 1'b1;
        in_data = x;
        exp_a = model(x, 64);
        exp_b = model(x, 40);
        step();
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input bit lock);
        int lat = 1;
        while (!out_valid_a && lat < 200) begin
            if (lock && lat == 5) begin
                cfg_we = 1'b1;
                cfg_addr = '0;
                cfg_tt = {$urandom, $urandom};
                cfg_idx = rand_idx();
                #1;
                chk("cfg_ready_run", 64'(cfg_ready_a), 64'd0);
                chk("in_ready_run", 64'(in_ready_a), 64'd0);
            end
            if (lat == 8) cfg_we = 1'b0;
            step();
            lat++;
        end
        cfg_we = 1'b0;
        chk("latency", 64'(lat), 64'd34);
        chk("out_valid_b", 64'(out_valid_b), 64'd1);
        chk("out_data_a", 64'(out_data_a), 64'(exp_a));
        chk("out_data_b", 64'(out_data_b), 64'(exp_b));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_data", 64'(out_data_a), 64'(exp_a));
            chk("hold_valid", 64'(out_valid_a), 64'd1);
            chk("hold_in_ready", 64'(in_ready_a), 64'd0);
            chk("hold_cfg_ready", 64'(cfg_ready_a), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid_a), 64'd0);
        chk("post_busy", 64'({busy_a, busy_b}), 64'd0);
        chk("post_in_ready", 64'(in_ready_a), 64'd1);
        chk("post_data", 64'(out_data_a), 64'd0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
        chk("rst_out_data", 64'(out_data_a), 64'd0);
        chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'({in_ready_a, cfg_ready_a}), 64'd3);

        for (int n = 0; n < 32; n++) cfg_write(n, 64'd0, 36'd0);
        cfg_write(0, 64'h8000_0000_0000_0000, idx6(5, 4, 3, 2, 1, 0));
        send(64'h3F);
        collect(0, 0);
        chk("and_hit", 64'(exp_a), 64'h1);
        send(64'h1F);
        collect(0, 0);
        chk("and_miss", 64'(out_data_a), 64'h0);

        cfg_write(31, 64'h2, idx6(62, 62, 62, 62, 62, 63));
        send(64'h8000_0000_0000_0000);
        collect(10, 0);
        chk("route_a", 64'(exp_a), 64'h8000_0000);
        send(64'hC000_0000_0000_0000);
        collect(0, 0);
        chk("route_b62", 64'(exp_a), 64'h0);

        cfg_write(1, 64'h2, idx6(1, 1, 1, 1, 1, 50));
        send(64'h0004_0000_0000_0000);
        collect(0, 0);
        chk("oor_idx_a", 64'(exp_a[1]), 64'd1);
        chk("oor_idx_b", 64'(exp_b[1]), 64'd0);

        cfg_write(40, 64'hFFFF_FFFF_FFFF_FFFF, 36'd0);
        send(64'h0004_0000_0000_0000);
        collect(0, 0);

        send(64'h3F);
        collect(0, 1);

        cfg_we = 1'b1;
        cfg_addr = 6'd2;
        cfg_tt = 64'h1;
        cfg_idx = 36'd0;
        in_valid = 1'b1;
        in_data = 64'h0;
        #1;
        chk("prio_in_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
        step();
        m_tt[2] = 64'h1;
        m_idx[2] = 36'd0;
        cfg_we = 1'b0;
        #1;
        chk("prio_next_ready", 64'(in_ready_a), 64'd1);
        exp_a = model(64'h0, 64);
        exp_b = model(64'h0, 40);
        step();
        in_valid = 1'b0;
        collect(0, 0);
        chk("prio_bit2", 64'(exp_a[2]), 64'd1);

        send(64'h3F);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
        chk("midrst_data", 64'(out_data_a), 64'd0);
        chk("midrst_busy", 64'({busy_a, busy_b}), 64'd0);
        rst_n = 1'b1;
        send(64'h3F);
        collect(0, 0);

        for (int n = 0; n < 32; n++) cfg_write(n, {$urandom, $urandom}, rand_idx());
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write($urandom_range(0, 47), {$urandom, $urandom}, rand_idx());
            send({$urandom, $urandom});
            collect($urandom_range(0, 3), t % 5 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
